// File: rtl/ssp_dma_pkg.sv
// Shared definitions for the SSP DMA request scheduler: FSM encoding,
// channel identifiers and legal parameter ranges.
package ssp_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CLR  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic CH_RX = 1'b0;
    localparam logic CH_TX = 1'b1;

    localparam int BURST_LEN_MIN   = 1;
    localparam int BURST_LEN_MAX   = 16;
    localparam int CLR_HOLDOFF_MIN = 1;
    localparam int CLR_HOLDOFF_MAX = 7;

endpackage

// File: rtl/ssp_dma_sched.sv
// Arbitrates SSP TX/RX DMA requests onto a single beat-level bus engine,
// then pulses the matching request-clear and holds off re-arbitration.
import ssp_dma_pkg::*;

module ssp_dma_sched #(
    parameter int BURST_LEN   = 4,
    parameter int CLR_HOLDOFF = 2
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic ENABLE,
    input  logic TXDMASREQ,
    input  logic TXDMABREQ,
    input  logic RXDMASREQ,
    input  logic RXDMABREQ,
    input  logic XFERACK,
    output logic XFERREQ,
    output logic XFERDIR,
    output logic TXDMACLR,
    output logic RXDMACLR,
    output logic BUSY
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BEATS_BURST  = CW'(BURST_LEN);
    localparam logic [CW-1:0] BEATS_SINGLE = CW'(1);
    localparam logic [2:0]    HOLD_LOAD    = 3'(CLR_HOLDOFF - 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      hold_cnt;
    logic            last;

    logic burst_any, tx_cand, rx_cand, any_req, grant_ch;

    // Bursts shadow singles; a same-class tie goes to the channel not served last.
    assign burst_any = TXDMABREQ | RXDMABREQ;
    assign tx_cand   = burst_any ? TXDMABREQ : TXDMASREQ;
    assign rx_cand   = burst_any ? RXDMABREQ : RXDMASREQ;
    assign any_req   = tx_cand | rx_cand;
    assign grant_ch  = (tx_cand && rx_cand) ? ~last : tx_cand;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            count    <= '0;
            hold_cnt <= '0;
            last     <= CH_TX;
            XFERREQ  <= 1'b0;
            XFERDIR  <= 1'b0;
            TXDMACLR <= 1'b0;
            RXDMACLR <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ENABLE && any_req) begin
                        state   <= ST_XFER;
                        XFERREQ <= 1'b1;
                        XFERDIR <= grant_ch;
                        BUSY    <= 1'b1;
                        count   <= burst_any ? BEATS_BURST : BEATS_SINGLE;
                    end
                end
                ST_XFER: begin
                    if (XFERACK) begin
                        // A dropped ENABLE lets only the in-flight beat finish.
                        if (count == BEATS_SINGLE || !ENABLE) begin
                            state    <= ST_CLR;
                            XFERREQ  <= 1'b0;
                            count    <= '0;
                            last     <= XFERDIR;
                            TXDMACLR <= (XFERDIR == CH_TX);
                            RXDMACLR <= (XFERDIR == CH_RX);
                        end else if (count != '0) begin
                            count <= count - BEATS_SINGLE;
                        end
                    end
                end
                ST_CLR: begin
                    state    <= ST_HOLD;
                    TXDMACLR <= 1'b0;
                    RXDMACLR <= 1'b0;
                    hold_cnt <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    if (hold_cnt == 3'd0) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
